// File: rtl/axi4lite_pkg.sv
// Shared types and default widths for the AXI4-Lite master, slave and command sequencer.
package axi4lite_pkg;

  localparam int ADDR_WIDTH = 2;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } seq_state_t;

  // Default-width command word; modules with overridden widths build their own equivalent.
  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/axi4lite_cmd_fifo.sv
// Synchronous FIFO with full/empty/count; the head entry is visible on dout without a pop.
module axi4lite_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = (count_reg == (PW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/axi4lite_cmd_sequencer.sv
// Queues read/write commands, issues them to the AXI4-Lite master one at a time,
// and returns each completion (or watchdog abort) on a valid/ready response port.
module axi4lite_cmd_sequencer #(
  parameter int ADDR_WIDTH = axi4lite_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi4lite_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  start_write,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_rw,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy
);
  import axi4lite_pkg::*;

  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } seq_cmd_t;

  localparam int          CW          = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

  seq_state_t            state_reg;
  logic [7:0]            wd_reg;
  logic                  rw_reg;
  logic                  start_write_reg;
  logic                  start_read_reg;
  logic [ADDR_WIDTH-1:0] m_addr_reg;
  logic [DATA_WIDTH-1:0] m_wdata_reg;
  logic                  rsp_valid_reg;
  logic                  rsp_rw_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  logic                  rsp_err_reg;

  seq_cmd_t              fifo_din;
  seq_cmd_t              fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW:0]           fifo_count;
  logic                  fifo_pop;
  logic [7:0]            wd_inc;

  assign fifo_din  = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
  assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;
  assign wd_inc    = wd_reg + 8'd1;

  axi4lite_cmd_fifo #(
    .WIDTH ($bits(seq_cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      wd_reg          <= '0;
      rw_reg          <= 1'b0;
      start_write_reg <= 1'b0;
      start_read_reg  <= 1'b0;
      m_addr_reg      <= '0;
      m_wdata_reg     <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rw_reg      <= 1'b0;
      rsp_data_reg    <= '0;
      rsp_err_reg     <= 1'b0;
    end else begin
      start_write_reg <= 1'b0;
      start_read_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            // Start pulses are registered here so they are high exactly during ISSUE.
            rw_reg          <= fifo_head.rw;
            m_addr_reg      <= fifo_head.addr;
            m_wdata_reg     <= fifo_head.wdata;
            start_write_reg <= fifo_head.rw;
            start_read_reg  <= !fifo_head.rw;
            state_reg       <= ISSUE;
          end
        end
        ISSUE: begin
          wd_reg    <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          wd_reg <= wd_inc;
          // A done arriving on the timeout cycle still counts as a clean completion.
          if (m_done) begin
            rsp_valid_reg <= 1'b1;
            rsp_rw_reg    <= rw_reg;
            rsp_data_reg  <= rw_reg ? '0 : m_rdata;
            rsp_err_reg   <= 1'b0;
            state_reg     <= RESP;
          end else if (wd_inc == TIMEOUT_CNT) begin
            rsp_valid_reg <= 1'b1;
            rsp_rw_reg    <= rw_reg;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b1;
            state_reg     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = !fifo_full;
  assign busy        = (state_reg != IDLE) || (fifo_count != '0);
  assign start_write = start_write_reg;
  assign start_read  = start_read_reg;
  assign m_addr      = m_addr_reg;
  assign m_wdata     = m_wdata_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rw      = rsp_rw_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_err     = rsp_err_reg;

endmodule

// File: tb/tb_axi4lite_cmd_sequencer.sv
// Scoreboard bench for axi4lite_cmd_sequencer: directed commands, a master model with
// per-command done delay, and a monitor that checks start pulses and responses.
module tb_axi4lite_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [1:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready;
  logic       start_write, start_read;
  logic [1:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata = 8'hEE;
  logic       m_done = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_rw;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  typedef struct { int delay; logic [7:0] rdata; } m_item_t;
  typedef struct { logic rw; logic [1:0] addr; logic [7:0] wdata; int cyc; } exp_start_t;
  typedef struct { logic rw; logic [7:0] data; logic err; int lat; } exp_rsp_t;

  m_item_t    mq[$];
  exp_start_t exp_start[$];
  exp_rsp_t   exp_rsp[$];
  int         start_cycs[$];

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  int n_starts = 0;

  axi4lite_cmd_sequencer #(
    .ADDR_WIDTH (2),
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .TIMEOUT    (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .start_write (start_write),
    .start_read  (start_read),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_rdata     (m_rdata),
    .m_done      (m_done),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rw      (rsp_rw),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Master model: each start pulse takes the next {delay, rdata}; delay 0 means never done.
  int         done_cnt = 0;
  logic [7:0] cur_rdata = 8'h00;
  always @(negedge clk) begin
    m_done  = 1'b0;
    m_rdata = 8'hEE;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        m_done  = 1'b1;
        m_rdata = cur_rdata;
      end
    end
    if ((start_write || start_read) && mq.size() > 0) begin
      m_item_t mi;
      mi        = mq.pop_front();
      done_cnt  = mi.delay;
      cur_rdata = mi.rdata;
    end
  end

  // Monitor: samples just after the falling edge, away from the active edge.
  logic       prev_start = 1'b0, prev_rv = 1'b0, prev_rr = 1'b1;
  logic       snap_rw = 1'b0, snap_err = 1'b0;
  logic [7:0] snap_data = '0;
  int         start_cyc = 0, rise_cyc = 0;
  always begin
    exp_start_t es;
    exp_rsp_t   er;
    @(negedge clk);
    #1;
    if (rst) begin
      prev_start = 1'b0;
      prev_rv    = 1'b0;
      prev_rr    = 1'b1;
    end else begin
      if (start_write || start_read) begin
        chk("start_onehot", start_write & start_read, 0);
        chk("start_single_cycle", prev_start, 0);
        chk("start_while_rsp_valid", rsp_valid, 0);
        chk("start_expected", exp_start.size() > 0, 1);
        if (exp_start.size() > 0) begin
          es = exp_start.pop_front();
          chk("start_rw", start_write, es.rw);
          chk("start_addr", m_addr, es.addr);
          if (es.rw) chk("start_wdata", m_wdata, es.wdata);
          if (es.cyc >= 0) chk("start_cycle", cyc, es.cyc);
        end
        start_cyc = cyc;
        start_cycs.push_back(cyc);
        n_starts++;
      end
      if (rsp_valid && !prev_rv) rise_cyc = cyc;
      if (rsp_valid && prev_rv && !prev_rr) begin
        chk("hold_rsp_rw", rsp_rw, snap_rw);
        chk("hold_rsp_data", rsp_data, snap_data);
        chk("hold_rsp_err", rsp_err, snap_err);
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", exp_rsp.size() > 0, 1);
        if (exp_rsp.size() > 0) begin
          er = exp_rsp.pop_front();
          chk("rsp_rw", rsp_rw, er.rw);
          chk("rsp_data", rsp_data, er.data);
          chk("rsp_err", rsp_err, er.err);
          chk("rsp_latency", rise_cyc - start_cyc, er.lat);
        end
      end
      prev_start = start_write || start_read;
      prev_rv    = rsp_valid;
      prev_rr    = rsp_ready;
      snap_rw    = rsp_rw;
      snap_data  = rsp_data;
      snap_err   = rsp_err;
    end
  end

  // Called at a falling edge; returns at a falling edge with cmd_valid low.
  task automatic issue(input logic rw, input logic [1:0] a, input logic [7:0] wd,
                       input int delay, input logic [7:0] rd,
                       input logic [7:0] exp_data, input logic exp_err, input int exp_lat,
                       input bit chk_cyc, input bit want_rsp, output int acc);
    bit ok = 1'b0;
    acc = -1;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("push_accepted", ok, 1);
    if (ok) begin
      mq.push_back('{delay, rd});
      exp_start.push_back('{rw, a, wd, chk_cyc ? acc + 2 : -1});
      if (want_rsp) exp_rsp.push_back('{rw, exp_data, exp_err, exp_lat});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && !rsp_valid && exp_rsp.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("idle_reached", ok, 1);
    @(negedge clk);
  endtask

  task automatic wait_starts(input int target, input int budget);
    for (int i = 0; i < budget && n_starts < target; i++) @(negedge clk);
    chk("start_seen", n_starts >= target, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc, base, sb;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_start_write", start_write, 0);
    chk("reset_start_read", start_read, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rw", rsp_rw, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_m_addr", m_addr, 0);
    chk("reset_m_wdata", m_wdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write addr 2 data A5, done 3 cycles after the start pulse.
    issue(1'b1, 2'd2, 8'hA5, 3, 8'hC3, 8'h00, 1'b0, 4, 1'b1, 1'b1, acc);
    wait_idle(100);

    // Read addr 1, master returns 3C.
    issue(1'b0, 2'd1, 8'h00, 2, 8'h3C, 8'h3C, 1'b0, 3, 1'b1, 1'b1, acc);
    wait_idle(100);

    // Reset while in WAIT; the late done must not produce a response.
    base = n_starts;
    issue(1'b0, 2'd3, 8'h00, 6, 8'h99, 8'h00, 1'b0, 0, 1'b1, 1'b0, acc);
    wait_starts(base + 1, 50);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_busy", busy, 0);
    chk("midreset_m_addr", m_addr, 0);
    chk("midreset_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("late_done_rsp_valid", rsp_valid, 0);
    chk("late_done_busy", busy, 0);

    // Blocker read that times out, then 5 commands queued behind it.
    base = n_starts;
    issue(1'b0, 2'd0, 8'h00, 0, 8'h00, 8'h00, 1'b1, 16, 1'b1, 1'b1, acc);
    wait_starts(base + 1, 50);
    sb = (start_cycs.size() > base) ? start_cycs[base] : 0;
    issue(1'b1, 2'd1, 8'h11, 2, 8'hC3, 8'h00, 1'b0, 3, 1'b0, 1'b1, acc);
    issue(1'b0, 2'd2, 8'h00, 1, 8'h22, 8'h22, 1'b0, 2, 1'b0, 1'b1, acc);
    issue(1'b1, 2'd3, 8'h33, 4, 8'hC3, 8'h00, 1'b0, 5, 1'b0, 1'b1, acc);
    issue(1'b0, 2'd0, 8'h00, 3, 8'h44, 8'h44, 1'b0, 4, 1'b0, 1'b1, acc);
    chk("cmd_ready_full", cmd_ready, 0);
    issue(1'b1, 2'd2, 8'h55, 1, 8'hC3, 8'h00, 1'b0, 2, 1'b0, 1'b1, acc);
    chk("fifth_accept_cycle", acc, sb + 18);
    wait_idle(300);

    // Done arriving on the timeout cycle wins.
    issue(1'b0, 2'd3, 8'h00, 15, 8'h5A, 8'h5A, 1'b0, 16, 1'b1, 1'b1, acc);
    wait_idle(100);

    // Backpressure: response held 10 cycles with a second command queued.
    rsp_ready = 1'b0;
    issue(1'b1, 2'd1, 8'h77, 1, 8'hC3, 8'h00, 1'b0, 2, 1'b1, 1'b1, acc);
    issue(1'b0, 2'd2, 8'h00, 1, 8'h88, 8'h88, 1'b0, 2, 1'b0, 1'b1, acc);
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    chk("hold_rsp_valid_seen", rsp_valid, 1);
    base = n_starts;
    repeat (10) @(negedge clk);
    chk("hold_no_start", n_starts, base);
    chk("hold_rsp_valid_kept", rsp_valid, 1);
    rsp_ready = 1'b1;
    wait_idle(100);

    chk("start_queue_drained", exp_start.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
